// File: rtl/ctrl_pkg.sv
// ctrl_pkg: opcodes, control enums, the ID/EX control bundle and its NOP value
package ctrl_pkg;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA,
    ALU_OR, ALU_AND, ALU_LUI, ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU
  } alu_op_e;
  typedef enum logic [2:0] {
    BR_NONE, BR_EQ, BR_NE, BR_LT, BR_GE, BR_LTU, BR_GEU, BR_JUMP
  } br_type_e;
  typedef enum logic [1:0] {
    WB_PC4 = 2'b00, WB_ALU = 2'b01, WB_MEM = 2'b11
  } wb_sel_e;
  typedef struct packed {
    logic     reg_wr;
    logic     rd_en;
    logic     wr_en;
    logic     sel_a;
    logic     sel_b;
    wb_sel_e  wb_sel;
    br_type_e br_type;
    alu_op_e  alu_op;
    logic     illegal;
  } ctrl_t;
  localparam ctrl_t CTRL_NOP = '{
    reg_wr: 1'b0, rd_en: 1'b0, wr_en: 1'b0, sel_a: 1'b0, sel_b: 1'b0,
    wb_sel: WB_ALU, br_type: BR_NONE, alu_op: ALU_ADD, illegal: 1'b0
  };
  function automatic alu_op_e alu_of(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction
  function automatic br_type_e br_of(input logic [2:0] f3);
    case (f3)
      3'b000:  return BR_EQ;
      3'b001:  return BR_NE;
      3'b100:  return BR_LT;
      3'b101:  return BR_GE;
      3'b110:  return BR_LTU;
      3'b111:  return BR_GEU;
      default: return BR_NONE;
    endcase
  endfunction
endpackage

// File: rtl/inst_decoder.sv
// inst_decoder: combinational RV32I(+M) decode of one instruction into the control bundle
module inst_decoder
  import ctrl_pkg::*;
#(
  parameter bit M_EXT = 1'b0
) (
  input  logic [31:0] inst,
  output ctrl_t       ctrl,
  output logic        uses_rs1,
  output logic        uses_rs2
);
  logic [6:0] op, f7;
  logic [2:0] f3;
  logic       bad;
  logic       unused_ok;
  ctrl_t      c;
  assign op = inst[6:0];
  assign f3 = inst[14:12];
  assign f7 = inst[31:25];
  assign unused_ok = ^inst[24:15];
  assign uses_rs1 = op inside {OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JALR};
  assign uses_rs2 = op inside {OP_R, OP_STORE, OP_BRANCH};
  always_comb begin
    c = CTRL_NOP;
    bad = 1'b0;
    case (op)
      OP_R: begin
        c.reg_wr = 1'b1;
        c.sel_a = 1'b1;
        if (f7 == 7'b0000001) begin
          c.alu_op = alu_op_e'(4'd11 + {2'b00, f3[1:0]});
          bad = !M_EXT || f3[2];
        end else begin
          c.alu_op = alu_of(f3, f7[5]);
          bad = !(f7 == 7'b0000000 || (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)));
        end
      end
      OP_IMM: begin
        c.reg_wr = 1'b1;
        c.sel_a = 1'b1;
        c.sel_b = 1'b1;
        c.alu_op = alu_of(f3, f3 == 3'b101 && f7[5]);
        bad = (f3 == 3'b001 && f7 != 7'b0) || (f3 == 3'b101 && f7 != 7'b0 && f7 != 7'b0100000);
      end
      OP_LOAD: begin
        c.reg_wr = 1'b1;
        c.rd_en = 1'b1;
        c.sel_a = 1'b1;
        c.sel_b = 1'b1;
        c.wb_sel = WB_MEM;
        bad = f3 == 3'b011 || f3[2:1] == 2'b11;
      end
      OP_STORE: begin
        c.wr_en = 1'b1;
        c.sel_a = 1'b1;
        c.sel_b = 1'b1;
        bad = f3 >= 3'b011;
      end
      OP_BRANCH: begin
        c.sel_b = 1'b1;
        c.br_type = br_of(f3);
        bad = f3[2:1] == 2'b01;
      end
      OP_JAL: begin
        c.reg_wr = 1'b1;
        c.sel_b = 1'b1;
        c.br_type = BR_JUMP;
        c.wb_sel = WB_PC4;
      end
      OP_JALR: begin
        c.reg_wr = 1'b1;
        c.sel_a = 1'b1;
        c.sel_b = 1'b1;
        c.br_type = BR_JUMP;
        c.wb_sel = WB_PC4;
        bad = f3 != 3'b000;
      end
      OP_LUI: begin
        c.reg_wr = 1'b1;
        c.sel_b = 1'b1;
        c.alu_op = ALU_LUI;
      end
      OP_AUIPC: begin
        c.reg_wr = 1'b1;
        c.sel_b = 1'b1;
      end
      default: bad = 1'b1;
    endcase
    if (bad) begin
      c = CTRL_NOP;
      c.illegal = 1'b1;
    end
    c.reg_wr = c.reg_wr && inst[11:7] != 5'd0;
  end
  assign ctrl = c;
endmodule

// File: rtl/decode_ctrl_stage.sv
// decode_ctrl_stage: ID decode into the ID/EX register with load-use hazard, stall/flush and perf counters
module decode_ctrl_stage
  import ctrl_pkg::*;
#(
  parameter bit M_EXT  = 1'b0,
  parameter int XLEN   = 32,
  parameter int PERF_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       inst_i,
  input  logic              inst_valid_i,
  input  logic [XLEN-1:0]   pc_i,
  input  logic              stall_i,
  input  logic              flush_i,
  output logic              ex_valid_o,
  output logic              reg_wr_o,
  output logic              rd_en_o,
  output logic              wr_en_o,
  output logic              sel_A_o,
  output logic              sel_B_o,
  output logic [1:0]        wb_sel_o,
  output logic [2:0]        br_type_o,
  output logic [3:0]        alu_op_o,
  output logic [4:0]        rs1_o,
  output logic [4:0]        rs2_o,
  output logic [4:0]        rd_o,
  output logic [2:0]        func3_o,
  output logic [XLEN-1:0]   pc_o,
  output logic              illegal_o,
  output logic              id_stall_o,
  output logic [PERF_W-1:0] bubble_cnt_o,
  output logic [PERF_W-1:0] illegal_cnt_o
);
  ctrl_t dec, dec_live, ex_ctrl;
  logic  uses_rs1, uses_rs2, load_use, bubble, adv;
  inst_decoder #(.M_EXT(M_EXT)) u_dec (
    .inst(inst_i),
    .ctrl(dec),
    .uses_rs1(uses_rs1),
    .uses_rs2(uses_rs2)
  );
  assign load_use = ex_valid_o && ex_ctrl.rd_en && rd_o != 5'd0 &&
                    ((uses_rs1 && inst_i[19:15] == rd_o) || (uses_rs2 && inst_i[24:20] == rd_o));
  assign bubble = inst_valid_i && load_use;
  assign id_stall_o = stall_i || (bubble && !flush_i);
  assign adv = !flush_i && !stall_i && inst_valid_i;
  always_comb begin
    dec_live = dec;
    dec_live.reg_wr = dec.reg_wr && inst_valid_i;
    dec_live.rd_en = dec.rd_en && inst_valid_i;
    dec_live.wr_en = dec.wr_en && inst_valid_i;
  end
  always_ff @(posedge clk) begin
    if (rst || flush_i || (!stall_i && bubble)) begin
      ex_valid_o <= 1'b0;
      ex_ctrl <= CTRL_NOP;
      {rs1_o, rs2_o, rd_o, func3_o} <= '0;
      pc_o <= '0;
    end else if (!stall_i) begin
      ex_valid_o <= inst_valid_i;
      ex_ctrl <= dec_live;
      rs1_o <= inst_i[19:15];
      rs2_o <= inst_i[24:20];
      rd_o <= inst_i[11:7];
      func3_o <= inst_i[14:12];
      pc_o <= pc_i;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      bubble_cnt_o <= '0;
      illegal_cnt_o <= '0;
    end else begin
      bubble_cnt_o <= bubble_cnt_o + PERF_W'(adv && load_use && !(&bubble_cnt_o));
      illegal_cnt_o <= illegal_cnt_o + PERF_W'(adv && !load_use && dec.illegal && !(&illegal_cnt_o));
    end
  end
  assign reg_wr_o = ex_ctrl.reg_wr;
  assign rd_en_o = ex_ctrl.rd_en;
  assign wr_en_o = ex_ctrl.wr_en;
  assign sel_A_o = ex_ctrl.sel_a;
  assign sel_B_o = ex_ctrl.sel_b;
  assign wb_sel_o = ex_ctrl.wb_sel;
  assign br_type_o = ex_ctrl.br_type;
  assign alu_op_o = ex_ctrl.alu_op;
  assign illegal_o = ex_ctrl.illegal;
endmodule

// File: tb/tb_decode_ctrl_stage.sv
// tb_decode_ctrl_stage: directed and randomized checks of decode_ctrl_stage against a behavioural model
module tb_decode_ctrl_stage;
  logic clk = 1'b0;
  logic rst, inst_valid_i, stall_i, flush_i;
  logic [31:0] inst_i, pc_i;
  logic ex_valid [2], reg_wr [2], rd_en [2], wr_en [2], sel_a [2], sel_b [2], illegal [2], id_stall [2];
  logic [1:0] wb_sel [2];
  logic [2:0] br_type [2], func3 [2];
  logic [3:0] alu_op [2];
  logic [4:0] rs1 [2], rs2 [2], rd [2];
  logic [31:0] pc [2];
  logic [15:0] bc0, ic0;
  logic [1:0] bc1, ic1;
  int vecs = 0, errs = 0;
  bit armed = 0;
  bit last_stall [2];
  always #5 clk = ~clk;
  decode_ctrl_stage #(.M_EXT(1'b0), .XLEN(32), .PERF_W(16)) u0 (
    .clk(clk), .rst(rst), .inst_i(inst_i), .inst_valid_i(inst_valid_i), .pc_i(pc_i),
    .stall_i(stall_i), .flush_i(flush_i), .ex_valid_o(ex_valid[0]), .reg_wr_o(reg_wr[0]),
    .rd_en_o(rd_en[0]), .wr_en_o(wr_en[0]), .sel_A_o(sel_a[0]), .sel_B_o(sel_b[0]),
    .wb_sel_o(wb_sel[0]), .br_type_o(br_type[0]), .alu_op_o(alu_op[0]), .rs1_o(rs1[0]),
    .rs2_o(rs2[0]), .rd_o(rd[0]), .func3_o(func3[0]), .pc_o(pc[0]), .illegal_o(illegal[0]),
    .id_stall_o(id_stall[0]), .bubble_cnt_o(bc0), .illegal_cnt_o(ic0)
  );
  decode_ctrl_stage #(.M_EXT(1'b1), .XLEN(32), .PERF_W(2)) u1 (
    .clk(clk), .rst(rst), .inst_i(inst_i), .inst_valid_i(inst_valid_i), .pc_i(pc_i),
    .stall_i(stall_i), .flush_i(flush_i), .ex_valid_o(ex_valid[1]), .reg_wr_o(reg_wr[1]),
    .rd_en_o(rd_en[1]), .wr_en_o(wr_en[1]), .sel_A_o(sel_a[1]), .sel_B_o(sel_b[1]),
    .wb_sel_o(wb_sel[1]), .br_type_o(br_type[1]), .alu_op_o(alu_op[1]), .rs1_o(rs1[1]),
    .rs2_o(rs2[1]), .rd_o(rd[1]), .func3_o(func3[1]), .pc_o(pc[1]), .illegal_o(illegal[1]),
    .id_stall_o(id_stall[1]), .bubble_cnt_o(bc1), .illegal_cnt_o(ic1)
  );
  typedef struct {
    bit v, rw, re, we, sa, sb, ill, u1, u2;
    int wb, br, alu, rs1, rs2, rd, f3;
    logic [31:0] pc;
    int bc, ic;
  } st_t;
  st_t m [2];
  int alu_tab [8] = '{0, 2, 3, 4, 5, 6, 8, 9};
  int br_tab [8] = '{1, 2, 0, 0, 3, 4, 5, 6};
  function automatic st_t nop();
    st_t s;
    s = '{default: 0};
    s.wb = 1;
    return s;
  endfunction
  function automatic st_t dec(input logic [31:0] x, input bit mext, input logic [31:0] pcv);
    st_t s = nop();
    int op = int'(x[6:0]);
    int f3 = int'(x[14:12]);
    int f7 = int'(x[31:25]);
    bit ok = 1;
    s.v = 1;
    s.rs1 = int'(x[19:15]);
    s.rs2 = int'(x[24:20]);
    s.rd = int'(x[11:7]);
    s.f3 = f3;
    s.pc = pcv;
    case (op)
      'h33: begin
        s.rw = 1; s.sa = 1; s.u1 = 1; s.u2 = 1;
        if (f7 == 0) s.alu = alu_tab[f3];
        else if (f7 == 'h20 && (f3 == 0 || f3 == 5)) s.alu = (f3 == 0) ? 1 : 7;
        else if (f7 == 1 && mext && f3 < 4) s.alu = 11 + f3;
        else ok = 0;
      end
      'h13: begin
        s.rw = 1; s.sa = 1; s.sb = 1; s.u1 = 1; s.alu = alu_tab[f3];
        if (f3 == 1 && f7 != 0) ok = 0;
        if (f3 == 5) begin
          if (f7 == 'h20) s.alu = 7;
          else if (f7 != 0) ok = 0;
        end
      end
      'h03: begin
        s.rw = 1; s.re = 1; s.sa = 1; s.sb = 1; s.wb = 3; s.u1 = 1;
        if (f3 == 3 || f3 >= 6) ok = 0;
      end
      'h23: begin
        s.we = 1; s.sa = 1; s.sb = 1; s.u1 = 1; s.u2 = 1;
        if (f3 >= 3) ok = 0;
      end
      'h63: begin
        s.sb = 1; s.u1 = 1; s.u2 = 1; s.br = br_tab[f3];
        if (f3 == 2 || f3 == 3) ok = 0;
      end
      'h6F: begin s.rw = 1; s.sb = 1; s.br = 7; s.wb = 0; end
      'h67: begin
        s.rw = 1; s.sa = 1; s.sb = 1; s.br = 7; s.wb = 0; s.u1 = 1;
        if (f3 != 0) ok = 0;
      end
      'h37: begin s.rw = 1; s.sb = 1; s.alu = 10; end
      'h17: begin s.rw = 1; s.sb = 1; end
      default: ok = 0;
    endcase
    if (!ok) begin
      s.rw = 0; s.re = 0; s.we = 0; s.sa = 0; s.sb = 0;
      s.wb = 1; s.br = 0; s.alu = 0; s.ill = 1;
    end
    if (s.rd == 0) s.rw = 0;
    return s;
  endfunction
  function automatic bit lu(input st_t e, input st_t d);
    return e.v && e.re && e.rd != 0 && ((d.u1 && d.rs1 == e.rd) || (d.u2 && d.rs2 == e.rd));
  endfunction
  function automatic logic [63:0] pk(input st_t s);
    return {30'd0, 1'(s.v), 1'(s.rw), 1'(s.re), 1'(s.we), 1'(s.sa), 1'(s.sb), 2'(s.wb),
            3'(s.br), 4'(s.alu), 5'(s.rs1), 5'(s.rs2), 5'(s.rd), 3'(s.f3), 1'(s.ill)};
  endfunction
  function automatic logic [63:0] dut_pk(input int i);
    return {30'd0, ex_valid[i], reg_wr[i], rd_en[i], wr_en[i], sel_a[i], sel_b[i], wb_sel[i],
            br_type[i], alu_op[i], rs1[i], rs2[i], rd[i], func3[i], illegal[i]};
  endfunction
  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h expected=%0h at %0t", nm, got, exp, $time);
    end
  endtask
  task automatic step(input logic [31:0] ins, input bit iv, input logic [31:0] pcv,
                      input bit st, input bit fl, input bit rs);
    st_t d, n;
    st_t nm [2];
    int mx;
    @(negedge clk);
    inst_i = ins; inst_valid_i = iv; pc_i = pcv; stall_i = st; flush_i = fl; rst = rs;
    #1;
    for (int i = 0; i < 2; i++) begin
      mx = (i == 1) ? 3 : 65535;
      d = dec(ins, i == 1, pcv);
      last_stall[i] = id_stall[i];
      if (armed) begin
        chk($sformatf("u%0d id_stall", i), 64'(id_stall[i]), 64'(st || (iv && lu(m[i], d) && !fl)));
        chk($sformatf("u%0d bundle", i), dut_pk(i), pk(m[i]));
        chk($sformatf("u%0d pc", i), 64'(pc[i]), 64'(m[i].pc));
        chk($sformatf("u%0d bubble_cnt", i), (i == 1) ? 64'(bc1) : 64'(bc0), 64'(m[i].bc));
        chk($sformatf("u%0d illegal_cnt", i), (i == 1) ? 64'(ic1) : 64'(ic0), 64'(m[i].ic));
      end
      n = m[i];
      if (rs) n = nop();
      else if (fl) begin
        n = nop(); n.bc = m[i].bc; n.ic = m[i].ic;
      end else if (st) n = m[i];
      else if (iv && lu(m[i], d)) begin
        n = nop(); n.ic = m[i].ic; n.bc = (m[i].bc < mx) ? m[i].bc + 1 : mx;
      end else begin
        n = d; n.v = iv;
        if (!iv) begin n.rw = 0; n.re = 0; n.we = 0; end
        n.bc = m[i].bc;
        n.ic = (iv && d.ill && m[i].ic < mx) ? m[i].ic + 1 : m[i].ic;
      end
      nm[i] = n;
    end
    @(posedge clk);
    m = nm;
    armed = 1;
    #1;
  endtask
  function automatic logic [31:0] rnd_inst();
    logic [6:0] ops [10] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h7F};
    logic [31:0] x = $urandom;
    x[6:0] = ops[$urandom_range(9)];
    x[11:7] = 5'($urandom_range(3));
    x[19:15] = 5'($urandom_range(3));
    x[24:20] = 5'($urandom_range(3));
    case ($urandom_range(3))
      0: x[31:25] = 7'h00;
      1: x[31:25] = 7'h20;
      2: x[31:25] = 7'h01;
      default: ;
    endcase
    return x;
  endfunction
  localparam logic [31:0] ADD = 32'h002081B3, LW = 32'h0000A283, ADDH = 32'h00728333;
  localparam logic [31:0] MUL = 32'h022081B3, BAD = 32'hFFFFFFFF, BEQ = 32'h00208463;
  initial begin
    m[0] = nop(); m[1] = nop();
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    chk("reset wb_sel", 64'(wb_sel[0]), 64'd1);
    chk("reset ex_valid", 64'(ex_valid[0]), 64'd0);
    step(ADD, 1, 32'h100, 0, 0, 0);
    chk("add reg_wr", 64'(reg_wr[0]), 64'd1);
    chk("add sel_A", 64'(sel_a[0]), 64'd1);
    chk("add sel_B", 64'(sel_b[0]), 64'd0);
    chk("add alu_op", 64'(alu_op[0]), 64'd0);
    chk("add wb_sel", 64'(wb_sel[0]), 64'd1);
    chk("add rd", 64'(rd[0]), 64'd3);
    step(LW, 1, 32'h104, 0, 0, 0);
    step(ADDH, 1, 32'h108, 0, 0, 0);
    chk("lu id_stall", 64'(last_stall[0]), 64'd1);
    chk("lu bubble ex_valid", 64'(ex_valid[0]), 64'd0);
    chk("lu bubble_cnt", 64'(bc0), 64'd1);
    step(ADDH, 1, 32'h108, 0, 0, 0);
    chk("lu release id_stall", 64'(last_stall[0]), 64'd0);
    chk("lu add captured rd", 64'(rd[0]), 64'd6);
    chk("lu add ex_valid", 64'(ex_valid[0]), 64'd1);
    step(0, 0, 0, 0, 0, 1);
    step(LW, 1, 32'h110, 0, 0, 0);
    step(ADDH, 1, 32'h114, 0, 1, 0);
    chk("flush id_stall", 64'(last_stall[0]), 64'd0);
    chk("flush ex_valid", 64'(ex_valid[0]), 64'd0);
    chk("flush bubble_cnt", 64'(bc0), 64'd0);
    step(MUL, 1, 32'h120, 0, 0, 0);
    chk("mul M1 alu_op", 64'(alu_op[1]), 64'hB);
    chk("mul M1 illegal", 64'(illegal[1]), 64'd0);
    chk("mul M0 illegal", 64'(illegal[0]), 64'd1);
    chk("mul M0 reg_wr", 64'(reg_wr[0]), 64'd0);
    chk("mul M0 ex_valid", 64'(ex_valid[0]), 64'd1);
    chk("mul M0 illegal_cnt", 64'(ic0), 64'd1);
    step(BAD, 1, 32'h124, 0, 0, 0);
    chk("ones illegal", 64'(illegal[1]), 64'd1);
    chk("ones illegal_cnt", 64'(ic0), 64'd2);
    step(BEQ, 1, 32'h200, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      step(ADD, 1, 32'h204, 1, 0, 0);
      chk("stall br_type", 64'(br_type[0]), 64'd1);
      chk("stall pc", 64'(pc[0]), 64'h200);
      chk("stall id_stall", 64'(last_stall[0]), 64'd1);
    end
    step(0, 0, 0, 0, 0, 1);
    for (int k = 0; k < 5; k++) step(BAD, 1, 32'h300, 0, 0, 0);
    chk("sat illegal_cnt W2", 64'(ic1), 64'd3);
    chk("sat illegal_cnt W16", 64'(ic0), 64'd5);
    step(ADDH, 1, 32'h304, 1, 1, 1);
    chk("rst ex_valid", 64'(ex_valid[1]), 64'd0);
    chk("rst illegal_cnt", 64'(ic1), 64'd0);
    chk("rst wb_sel", 64'(wb_sel[1]), 64'd1);
    chk("rst pc", 64'(pc[1]), 64'd0);
    chk("rst illegal", 64'(illegal[1]), 64'd0);
    for (int k = 0; k < 3000; k++)
      step(rnd_inst(), $urandom_range(9) < 8, $urandom, $urandom_range(7) == 0,
           $urandom_range(9) == 0, $urandom_range(99) == 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
